// File: rtl/flow_bus_serializer_if.sv
// Flow-bus serializer port bundle: wide upstream side, narrow downstream side.
// down_last exists only when FLOW_BUS_SERIALIZER_LAST_EN is defined.
interface flow_bus_serializer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DATA_NUM   = 2
);
  logic                           up_ready;
  logic                           up_valid;
  logic [DATA_WIDTH*DATA_NUM-1:0] up_data;
  logic                           down_ready;
  logic                           down_valid;
  logic [DATA_WIDTH-1:0]          down_data;
`ifdef FLOW_BUS_SERIALIZER_LAST_EN
  logic                           down_last;
`endif

  // master: the serializer itself; slave: the surrounding source/sink
`ifdef FLOW_BUS_SERIALIZER_LAST_EN
  modport master (input up_valid, up_data, down_ready,
                  output up_ready, down_valid, down_data, down_last);
  modport slave  (output up_valid, up_data, down_ready,
                  input up_ready, down_valid, down_data, down_last);
`else
  modport master (input up_valid, up_data, down_ready,
                  output up_ready, down_valid, down_data);
  modport slave  (output up_valid, up_data, down_ready,
                  input up_ready, down_valid, down_data);
`endif
endinterface

// File: rtl/flow_bus_serializer.sv
// Splits one wide word into DATA_NUM narrow words, least-significant slice first.
// Optional down_last output enabled by defining FLOW_BUS_SERIALIZER_LAST_EN.
module flow_bus_serializer #(
  parameter int DATA_WIDTH = 8,
  parameter int DATA_NUM   = 2,
  parameter int USE_ENABLE = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  flow_bus_serializer_if.master bus,
  output logic                  dbg_state
);
  localparam int WIDE  = DATA_WIDTH * DATA_NUM;
  localparam int CNT_W = (DATA_NUM > 1) ? $clog2(DATA_NUM) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_NUM - 1);

  typedef enum logic {EMPTY = 1'b0, SENDING = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDE-1:0]  hreg_q, hreg_d;
  logic             active;
  logic             on_last;
  logic             up_xfer;
  logic             dn_xfer;

  // Handshake: a beat moves on a side only in a cycle where valid and ready are
  // both high; valid never drops before its beat moves and data holds meanwhile.
  // Reset and (optionally) enable mask both sides combinationally.
  assign active  = ~rst & ((USE_ENABLE != 0) ? enable : 1'b1);
  assign on_last = (cnt_q == LAST);
  assign up_xfer = bus.up_valid & bus.up_ready;
  assign dn_xfer = bus.down_valid & bus.down_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      cnt_q   <= '0;
      hreg_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hreg_q  <= hreg_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hreg_d  = hreg_q;
    if (state_q == SENDING) begin
      if (dn_xfer) begin
        if (!on_last) begin
          hreg_d = hreg_q >> DATA_WIDTH;
          cnt_d  = cnt_q + CNT_W'(1);
        end else if (up_xfer) begin
          // Last slice leaves while the next word arrives: no bubble.
          hreg_d = bus.up_data;
          cnt_d  = '0;
        end else begin
          state_d = EMPTY;
        end
      end
    end else if (up_xfer) begin
      hreg_d  = bus.up_data;
      cnt_d   = '0;
      state_d = SENDING;
    end
  end

  always_comb begin
    bus.up_ready   = active & ((state_q == EMPTY) | (bus.down_ready & on_last));
    bus.down_valid = active & (state_q == SENDING);
    bus.down_data  = rst ? '0 : hreg_q[DATA_WIDTH-1:0];
`ifdef FLOW_BUS_SERIALIZER_LAST_EN
    bus.down_last  = active & (state_q == SENDING) & on_last;
`endif
    dbg_state      = (state_q == SENDING);
  end
endmodule

// File: tb/tb_flow_bus_serializer.sv
// Directed bench for flow_bus_serializer: N=4 with enable, N=2 random stream, N=1 pass-through.
module tb_flow_bus_serializer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b1;
  int   checks = 0;
  int   failures = 0;
  logic dbg4, dbg2, dbg1;

  always #5 clk = ~clk;

  flow_bus_serializer_if #(.DATA_WIDTH(8), .DATA_NUM(4)) bus4();
  flow_bus_serializer_if #(.DATA_WIDTH(8), .DATA_NUM(2)) bus2();
  flow_bus_serializer_if #(.DATA_WIDTH(8), .DATA_NUM(1)) bus1();

  flow_bus_serializer #(.DATA_WIDTH(8), .DATA_NUM(4), .USE_ENABLE(1)) u_dut4 (
    .clk(clk), .rst(rst), .enable(enable), .bus(bus4), .dbg_state(dbg4));
  // enable tied low: must be ignored when USE_ENABLE=0
  flow_bus_serializer #(.DATA_WIDTH(8), .DATA_NUM(2), .USE_ENABLE(0)) u_dut2 (
    .clk(clk), .rst(rst), .enable(1'b0), .bus(bus2), .dbg_state(dbg2));
  flow_bus_serializer #(.DATA_WIDTH(8), .DATA_NUM(1), .USE_ENABLE(0)) u_dut1 (
    .clk(clk), .rst(rst), .enable(1'b1), .bus(bus1), .dbg_state(dbg1));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick();
    tick();
    #2;
    checks++; if (bus4.up_ready !== 1'b0) begin failures++; $display("FAIL rst_up_ready got=%b exp=0", bus4.up_ready); end
    checks++; if (bus4.down_valid !== 1'b0) begin failures++; $display("FAIL rst_down_valid got=%b exp=0", bus4.down_valid); end
    checks++; if (bus4.down_data !== 8'h00) begin failures++; $display("FAIL rst_down_data got=%h exp=00", bus4.down_data); end
    checks++; if (bus2.up_ready !== 1'b0) begin failures++; $display("FAIL rst_up_ready2 got=%b exp=0", bus2.up_ready); end
    rst = 1'b0;
    #2;
    checks++; if (bus4.up_ready !== 1'b1) begin failures++; $display("FAIL post_rst_up_ready got=%b exp=1", bus4.up_ready); end
    checks++; if (bus4.down_valid !== 1'b0) begin failures++; $display("FAIL post_rst_down_valid got=%b exp=0", bus4.down_valid); end
    checks++; if ({dbg4, dbg2, dbg1} !== 3'b000) begin failures++; $display("FAIL post_rst_state got=%b exp=000", {dbg4, dbg2, dbg1}); end
    tick();
  endtask

  task automatic test_single_word();
    logic [31:0] w;
    w = 32'hDDCCBBAA;
    bus4.up_data = w; bus4.up_valid = 1'b1; bus4.down_ready = 1'b1;
    #2;
    checks++; if (bus4.up_ready !== 1'b1) begin failures++; $display("FAIL single_accept got=%b exp=1", bus4.up_ready); end
    tick();
    bus4.up_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #2;
      checks++; if (bus4.down_valid !== 1'b1) begin failures++; $display("FAIL single_valid beat=%0d got=%b exp=1", i, bus4.down_valid); end
      checks++; if (bus4.down_data !== w[i*8 +: 8]) begin failures++; $display("FAIL single_data beat=%0d got=%h exp=%h", i, bus4.down_data, w[i*8 +: 8]); end
      checks++; if (bus4.up_ready !== (i == 3)) begin failures++; $display("FAIL single_up_ready beat=%0d got=%b exp=%b", i, bus4.up_ready, (i == 3)); end
      tick();
    end
    #2;
    checks++; if (bus4.down_valid !== 1'b0) begin failures++; $display("FAIL single_drained got=%b exp=0", bus4.down_valid); end
    tick();
  endtask

  task automatic test_back_to_back();
    bus4.up_data = 32'h03020100; bus4.up_valid = 1'b1; bus4.down_ready = 1'b1;
    tick();
    bus4.up_data = 32'h07060504;
    for (int i = 0; i < 8; i++) begin
      #2;
      checks++; if (bus4.down_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid beat=%0d got=%b exp=1", i, bus4.down_valid); end
      checks++; if (bus4.down_data !== 8'(i)) begin failures++; $display("FAIL b2b_data beat=%0d got=%h exp=%h", i, bus4.down_data, 8'(i)); end
      checks++; if (bus4.up_ready !== (i == 3 || i == 7)) begin failures++; $display("FAIL b2b_up_ready beat=%0d got=%b exp=%b", i, bus4.up_ready, (i == 3 || i == 7)); end
      tick();
      if (i == 3) bus4.up_valid = 1'b0;
    end
    #2;
    checks++; if (bus4.down_valid !== 1'b0) begin failures++; $display("FAIL b2b_drained got=%b exp=0", bus4.down_valid); end
    tick();
  endtask

  task automatic test_stall();
    bit   pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int   idx = 0;
    int   c = 0;
    logic rdy;
    logic [7:0] e;
    bus4.up_data = 32'h0D0C0B0A; bus4.up_valid = 1'b1; bus4.down_ready = 1'b0;
    tick();
    bus4.up_valid = 1'b0;
    while (idx < 4 && c < 20) begin
      rdy = pat[c % 4];
      bus4.down_ready = rdy;
      e = 8'h0A + 8'(idx);
      #2;
      checks++; if (bus4.down_valid !== 1'b1) begin failures++; $display("FAIL stall_valid cyc=%0d got=%b exp=1", c, bus4.down_valid); end
      checks++; if (bus4.down_data !== e) begin failures++; $display("FAIL stall_data cyc=%0d got=%h exp=%h", c, bus4.down_data, e); end
      checks++; if (bus4.up_ready !== (rdy && idx == 3)) begin failures++; $display("FAIL stall_up_ready cyc=%0d got=%b exp=%b", c, bus4.up_ready, (rdy && idx == 3)); end
      tick();
      if (rdy) idx++;
      c++;
    end
    checks++; if (idx != 4) begin failures++; $display("FAIL stall_timeout got=%0d slices exp=4", idx); end
    bus4.down_ready = 1'b1;
    #2;
    checks++; if (bus4.down_valid !== 1'b0) begin failures++; $display("FAIL stall_drained got=%b exp=0", bus4.down_valid); end
    tick();
  endtask

  task automatic test_reset_mid();
    logic [31:0] w;
    bus4.up_data = 32'h88776655; bus4.up_valid = 1'b1; bus4.down_ready = 1'b1;
    tick();
    bus4.up_valid = 1'b0;
    #2;
    checks++; if (bus4.down_data !== 8'h55) begin failures++; $display("FAIL rmid_s0 got=%h exp=55", bus4.down_data); end
    tick();
    #2;
    checks++; if (bus4.down_data !== 8'h66) begin failures++; $display("FAIL rmid_s1 got=%h exp=66", bus4.down_data); end
    tick();
    rst = 1'b1;
    #2;
    checks++; if (bus4.down_valid !== 1'b0) begin failures++; $display("FAIL rmid_in_rst_valid got=%b exp=0", bus4.down_valid); end
    checks++; if (bus4.down_data !== 8'h00) begin failures++; $display("FAIL rmid_in_rst_data got=%h exp=00", bus4.down_data); end
    tick();
    rst = 1'b0;
    #2;
    checks++; if (bus4.down_valid !== 1'b0) begin failures++; $display("FAIL rmid_after_valid got=%b exp=0", bus4.down_valid); end
    checks++; if (bus4.up_ready !== 1'b1) begin failures++; $display("FAIL rmid_after_up_ready got=%b exp=1", bus4.up_ready); end
    w = 32'h44332211;
    bus4.up_data = w; bus4.up_valid = 1'b1;
    tick();
    bus4.up_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #2;
      checks++; if (bus4.down_valid !== 1'b1 || bus4.down_data !== w[i*8 +: 8]) begin failures++; $display("FAIL rmid_next beat=%0d got=%b/%h exp=1/%h", i, bus4.down_valid, bus4.down_data, w[i*8 +: 8]); end
      tick();
    end
  endtask

  task automatic test_enable();
    logic [31:0] w;
    w = 32'hA3A2A1A0;
    bus4.up_data = w; bus4.up_valid = 1'b1; bus4.down_ready = 1'b1;
    tick();
    bus4.up_valid = 1'b0;
    #2;
    checks++; if (bus4.down_data !== 8'hA0) begin failures++; $display("FAIL en_s0 got=%h exp=a0", bus4.down_data); end
    tick();
    enable = 1'b0;
    bus4.up_data = 32'h55555555; bus4.up_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #2;
      checks++; if (bus4.down_valid !== 1'b0) begin failures++; $display("FAIL en_off_valid cyc=%0d got=%b exp=0", i, bus4.down_valid); end
      checks++; if (bus4.up_ready !== 1'b0) begin failures++; $display("FAIL en_off_up_ready cyc=%0d got=%b exp=0", i, bus4.up_ready); end
      checks++; if (dbg4 !== 1'b1) begin failures++; $display("FAIL en_off_state cyc=%0d got=%b exp=1", i, dbg4); end
      tick();
    end
    enable = 1'b1;
    bus4.up_valid = 1'b0;
    for (int i = 1; i < 4; i++) begin
      #2;
      checks++; if (bus4.down_valid !== 1'b1 || bus4.down_data !== w[i*8 +: 8]) begin failures++; $display("FAIL en_resume beat=%0d got=%b/%h exp=1/%h", i, bus4.down_valid, bus4.down_data, w[i*8 +: 8]); end
      tick();
    end
    #2;
    checks++; if (bus4.down_valid !== 1'b0) begin failures++; $display("FAIL en_drained got=%b exp=0", bus4.down_valid); end
    tick();
  endtask

  task automatic test_single_slice();
    bus1.up_data = 8'h5A; bus1.up_valid = 1'b1; bus1.down_ready = 1'b1;
    #2;
    checks++; if (bus1.up_ready !== 1'b1 || bus1.down_valid !== 1'b0) begin failures++; $display("FAIL n1_c0 got=%b/%b exp=1/0", bus1.up_ready, bus1.down_valid); end
    tick();
    bus1.up_data = 8'hC3;
    #2;
    checks++; if (bus1.down_valid !== 1'b1 || bus1.down_data !== 8'h5A) begin failures++; $display("FAIL n1_c1_data got=%b/%h exp=1/5a", bus1.down_valid, bus1.down_data); end
    checks++; if (bus1.up_ready !== 1'b1) begin failures++; $display("FAIL n1_c1_up_ready got=%b exp=1", bus1.up_ready); end
`ifdef FLOW_BUS_SERIALIZER_LAST_EN
    checks++; if (bus1.down_last !== 1'b1) begin failures++; $display("FAIL n1_last got=%b exp=1", bus1.down_last); end
`endif
    tick();
    bus1.down_ready = 1'b0; bus1.up_data = 8'h11;
    #2;
    checks++; if (bus1.down_data !== 8'hC3 || bus1.up_ready !== 1'b0) begin failures++; $display("FAIL n1_c2 got=%h/%b exp=c3/0", bus1.down_data, bus1.up_ready); end
    tick();
    bus1.down_ready = 1'b1;
    #2;
    checks++; if (bus1.down_data !== 8'hC3 || bus1.up_ready !== 1'b1) begin failures++; $display("FAIL n1_c3 got=%h/%b exp=c3/1", bus1.down_data, bus1.up_ready); end
    tick();
    bus1.up_valid = 1'b0;
    #2;
    checks++; if (bus1.down_valid !== 1'b1 || bus1.down_data !== 8'h11) begin failures++; $display("FAIL n1_c4 got=%b/%h exp=1/11", bus1.down_valid, bus1.down_data); end
    tick();
    #2;
    checks++; if (bus1.down_valid !== 1'b0 || dbg1 !== 1'b0) begin failures++; $display("FAIL n1_c5 got=%b/%b exp=0/0", bus1.down_valid, dbg1); end
    tick();
  endtask

  task automatic test_random_stream();
    logic [7:0]  exp_q[$];
    logic [7:0]  e;
    logic [7:0]  prev_data = 8'h00;
    logic        prev_stall = 1'b0;
    logic        accepted;
    logic [15:0] w;
    int sent = 0, recv = 0, beat = 0, cyc = 0;
    bus2.up_valid = 1'b0;
    while ((sent < 100 || exp_q.size() > 0) && cyc < 3000) begin
      if (!bus2.up_valid && sent < 100 && $urandom_range(0, 3) != 0) begin
        w = 16'($urandom());
        bus2.up_data = w;
        bus2.up_valid = 1'b1;
      end
      bus2.down_ready = ($urandom_range(0, 2) != 0);
      #2;
      if (prev_stall) begin
        checks++; if (bus2.down_valid !== 1'b1 || bus2.down_data !== prev_data) begin failures++; $display("FAIL rnd_hold cyc=%0d got=%b/%h exp=1/%h", cyc, bus2.down_valid, bus2.down_data, prev_data); end
      end
      if (bus2.down_valid === 1'b1 && bus2.down_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL rnd_extra cyc=%0d got=%h exp=none", cyc, bus2.down_data);
        end else begin
          e = exp_q.pop_front();
          if (bus2.down_data !== e) begin failures++; $display("FAIL rnd_data beat=%0d got=%h exp=%h", beat, bus2.down_data, e); end
        end
`ifdef FLOW_BUS_SERIALIZER_LAST_EN
        checks++; if (bus2.down_last !== ((beat % 2) == 1)) begin failures++; $display("FAIL rnd_last beat=%0d got=%b exp=%b", beat, bus2.down_last, ((beat % 2) == 1)); end
`endif
        beat++;
        recv++;
      end
      accepted = 1'b0;
      if (bus2.up_valid && bus2.up_ready === 1'b1) begin
        exp_q.push_back(bus2.up_data[7:0]);
        exp_q.push_back(bus2.up_data[15:8]);
        sent++;
        accepted = 1'b1;
      end
      prev_stall = (bus2.down_valid === 1'b1) && !bus2.down_ready;
      prev_data  = bus2.down_data;
      tick();
      if (accepted) bus2.up_valid = 1'b0;
      cyc++;
    end
    checks++; if (recv != 200) begin failures++; $display("FAIL rnd_count got=%0d beats exp=200 (cycles=%0d)", recv, cyc); end
    bus2.up_valid = 1'b0;
    bus2.down_ready = 1'b0;
  endtask

  initial begin
    bus4.up_valid = 1'b0; bus4.up_data = '0; bus4.down_ready = 1'b0;
    bus2.up_valid = 1'b0; bus2.up_data = '0; bus2.down_ready = 1'b0;
    bus1.up_valid = 1'b0; bus1.up_data = '0; bus1.down_ready = 1'b0;
    test_reset();
    test_single_word();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_enable();
    test_single_slice();
    test_random_stream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
